// File: rtl/win_reader.sv
// win_reader: read-side client of the image memory.
// After a start pulse, walks every valid KxK window of an IMG_H x IMG_W image
// in raster order. For each window it issues K*K read addresses (one per
// cycle), captures the combinational read data into a window register, then
// offers the packed window downstream over a valid/ready handshake.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      begin a full image scan (sampled only when idle)
//   busy_o       high whenever a scan is in progress
//   done_o       one-cycle pulse after the final window handshake
//   mem_raddr_o  read address to the image memory
//   mem_rdata_i  read data, combinational from mem_raddr_o
//   win_valid_o  window data valid
//   win_ready_i  downstream accepts the window
//   win_data_o   packed window, slot ky*K+kx at [slot*DW +: DW]
//   win_row_o    row of the window's top-left pixel
//   win_col_o    column of the window's top-left pixel
//   win_last_o   high with win_valid_o for the final window
module win_reader #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int K     = 3,
    parameter int DW    = 8,
    parameter int AW    = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [AW-1:0]     mem_raddr_o,
    input  logic [DW-1:0]     mem_rdata_i,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic [K*K*DW-1:0] win_data_o,
    output logic [7:0]        win_row_o,
    output logic [7:0]        win_col_o,
    output logic              win_last_o
);

    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int SW = (K * K > 1) ? $clog2(K * K) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        OUT
    } state_t;

    state_t             state, state_next;
    logic [7:0]         row, col;
    logic [KW-1:0]      ky, kx;
    logic [SW-1:0]      slot;
    logic [K*K*DW-1:0]  win_data;
    logic               done;
    logic               last_win;
    logic               load_start, step_fetch, advance, finish;

    assign last_win = (row == 8'(IMG_H - K)) && (col == 8'(IMG_W - K));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_start = 1'b0;
        step_fetch = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = FETCH;
                    load_start = 1'b1;
                end
            end
            FETCH: begin
                step_fetch = 1'b1;
                if (slot == SW'(K * K - 1)) state_next = OUT;
            end
            OUT: begin
                if (win_ready_i) begin
                    if (last_win) begin
                        state_next = IDLE;
                        finish     = 1'b1;
                    end else begin
                        state_next = FETCH;
                        advance    = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row      <= '0;
            col      <= '0;
            ky       <= '0;
            kx       <= '0;
            slot     <= '0;
            win_data <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (load_start) begin
                row  <= '0;
                col  <= '0;
                ky   <= '0;
                kx   <= '0;
                slot <= '0;
            end
            if (step_fetch) begin
                // Constant-index capture keeps the slot decode free of
                // variable part-selects.
                for (int unsigned s = 0; s < K * K; s++) begin
                    if (slot == SW'(s)) win_data[s*DW +: DW] <= mem_rdata_i;
                end
                // kx/ky/slot all wrap back to 0 on the final slot, so the
                // next window starts from a clean kernel position.
                slot <= (slot == SW'(K * K - 1)) ? '0 : slot + SW'(1);
                if (kx == KW'(K - 1)) begin
                    kx <= '0;
                    ky <= (ky == KW'(K - 1)) ? '0 : ky + KW'(1);
                end else begin
                    kx <= kx + KW'(1);
                end
            end
            if (advance) begin
                if (col == 8'(IMG_W - K)) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

    always_comb begin
        mem_raddr_o = '0;
        if (state == FETCH)
            mem_raddr_o = AW'((32'(row) + 32'(ky)) * 32'(IMG_W) + 32'(col) + 32'(kx));
    end

    assign busy_o      = (state != IDLE);
    assign done_o      = done;
    assign win_valid_o = (state == OUT);
    assign win_last_o  = (state == OUT) && last_win;
    assign win_data_o  = win_data;
    assign win_row_o   = row;
    assign win_col_o   = col;

endmodule

// File: doc/win_reader.md
Name: win_reader

Overview:
- Read-side client of the 16x16 8-bit image memory.
- After a start pulse, walks every valid 3x3 convolution window in raster order.
- For each window it drives 9 memory read addresses and captures the combinational read data into a window register.
- It then presents the packed window to the downstream MAC array over a valid/ready handshake.

Parameters:
IMG_W, 16, image width in pixels
IMG_H, 16, image height in pixels
K, 3, window edge (window holds K*K pixels)
DW, 8, pixel width
AW, 8, memory address width (must satisfy 2^AW >= IMG_W*IMG_H)

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_ni  input  1  reset, asynchronous assert, active-low
start_i  input  1  begin a full image scan; sampled only in IDLE
busy_o  output  1  high in any state other than IDLE
done_o  output  1  one-cycle pulse after the final window handshake
mem_raddr_o  output  AW  read address to the image memory
mem_rdata_i  input  DW  read data; combinational function of mem_raddr_o, same cycle
win_valid_o  output  1  window data valid
win_ready_i  input  1  downstream accepts the window
win_data_o  output  K*K*DW  packed window; slot s at bits [s*DW +: DW], slot = ky*K+kx, slot 0 = top-left
win_row_o  output  8  row of the window's top-left pixel
win_col_o  output  8  column of the window's top-left pixel
win_last_o  output  1  high with win_valid_o for window (IMG_H-K, IMG_W-K)

Behaviour:
- Reset (rst_ni=0, asynchronous): state=IDLE; all counters 0; every output 0, including win_data_o. Reset mid-scan aborts the scan immediately. No done_o is produced. The next scan requires a new start_i.
- States: IDLE, FETCH, OUT.
- IDLE:
  - mem_raddr_o=0.
  - start_i=1 at an edge -> FETCH; row=0, col=0, ky=0, kx=0.
- FETCH:
  - mem_raddr_o = (row+ky)*IMG_W + (col+kx), computed at AW bits. The sum never overflows for legal parameters.
  - Each edge writes mem_rdata_i into slot ky*K+kx, then advances kx. When kx wraps to 0, ky advances.
  - After slot K*K-1 is captured -> OUT.
  - Exactly K*K cycles per window.
- OUT:
  - win_valid_o=1; mem_raddr_o=0.
  - win_data_o, win_row_o, win_col_o and win_last_o are held stable while win_valid_o=1 and win_ready_i=0.
  - On handshake (valid & ready at an edge):
    - If last window -> IDLE, and done_o=1 for the following cycle only.
    - Else col++. If col wraps past IMG_W-K, col=0 and row++. Then -> FETCH with ky=kx=0.
- win_valid_o is never asserted in FETCH. There is no overlap of fetch and output.
- Latency:
  - start_i sampled at edge N -> FETCH cycles N+1..N+K*K; win_valid_o rises in cycle N+K*K+1.
  - With win_ready_i tied high, throughput is one window per K*K+1 cycles.
- start_i while busy_o=1 is ignored and does not restart the scan.
- win_ready_i outside OUT is ignored.
- The block never writes the memory. Concurrent external writes are not arbitrated: whatever mem_rdata_i shows at the capture edge is captured.
- Window count per scan: (IMG_H-K+1)*(IMG_W-K+1) = 196 at defaults.
- busy_o is high from the cycle after start is sampled until the cycle done_o is high. In the done_o cycle the block is already in IDLE, so busy_o=0, and a start_i in that cycle is accepted.

Test Plan:
- Memory preloaded with mem[i]=i, pulse start_i, ready high -> first window row=0, col=0, slots = 0,1,2,16,17,18,32,33,34. win_valid_o rises exactly 10 cycles after the start edge.
- Hold win_ready_i low for 5 cycles on window (0,0) -> win_valid_o stays 1; win_data_o, win_row_o, win_col_o unchanged; no mem_raddr_o activity. The release handshake advances to (0,1) with slot0=1.
- Row wrap: window (0,13) has slot0=13 and slot8=47. The next window is (1,0) with slot0=16 and slot8=50.
- Full scan with ready high -> 196 handshakes. The last is (13,13) with slot0=221, slot8=255 and win_last_o=1. done_o pulses at start edge +1961, once, and busy_o then reads 0.
- Pulse start_i again mid-scan -> scan order and window count unaffected.
- Assert rst_ni low during FETCH of window (2,5) -> all outputs 0 immediately and no done_o. A new start after release restarts at (0,0).
